// File: rtl/serial_seq_pkg.sv
// Shared types and constants for the serial bit-stream transmitter.
package serial_seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serial_seq_if.sv
// Word handshake plus serial stream outputs of serial_seq_tx.
interface serial_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, out, out_valid, busy, word_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, out, out_valid, busy, word_done
    );
endinterface

// File: rtl/serial_seq_shreg.sv
// Load/shift register; o_head_nxt is the head bit the register will hold after this edge,
// so the owner can register it straight onto the serial output.
module serial_seq_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_head_nxt
);
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;

    always_comb begin
        w_data_nxt = r_data;
        if (i_load) begin
            w_data_nxt = i_data;
        end else if (i_shift) begin
            w_data_nxt = MSB_FIRST ? {r_data[WIDTH-2:0], 1'b0} : {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_head_nxt = MSB_FIRST ? w_data_nxt[WIDTH-1] : w_data_nxt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_data_nxt;
        end
    end
endmodule

// File: rtl/serial_seq_tx.sv
// Serial transmitter: accepts words over valid/ready, shifts them out one bit per clock,
// then holds the line idle for GAP cycles. All stream outputs come straight from flops.
module serial_seq_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_seq_if.slave bus
);
    import serial_seq_pkg::tx_state_t;
    import serial_seq_pkg::IDLE;
    import serial_seq_pkg::SHIFT;
    import serial_seq_pkg::GAP_CNT_W;

    localparam int                   CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    tx_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [GAP_CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic                 r_out, r_out_valid, r_word_done;
    logic                 w_ready, w_accept, w_load, w_shift, w_head_nxt;

    // Ready depends only on state and counters so upstream can never form a loop through it.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            SHIFT:   w_ready = (GAP == 0) && (r_bit_cnt == '0);
            default: w_ready = (r_gap_cnt == '0);
        endcase
    end

    assign w_accept = bus.data_valid && w_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = CNT_LAST;
                    w_load        = 1'b1;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_cnt != '0) begin
                    w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                end else if (GAP > 0) begin
                    w_state_nxt   = serial_seq_pkg::GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                end else if (w_accept) begin
                    w_bit_cnt_nxt = CNT_LAST;
                    w_load        = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                if (r_gap_cnt != '0) begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end else if (w_accept) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = CNT_LAST;
                    w_load        = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_out       <= (w_state_nxt == SHIFT) && w_head_nxt;
            r_out_valid <= (w_state_nxt == SHIFT);
            r_word_done <= (w_state_nxt == SHIFT) && (w_bit_cnt_nxt == '0);
        end
    end

    serial_seq_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (bus.data_in),
        .o_head_nxt (w_head_nxt)
    );

    assign bus.data_ready = w_ready;
    assign bus.out        = r_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.word_done  = r_word_done;
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench for serial_seq_tx: four instances cover GAP=1/0/3 and both bit orders.
`timescale 1ns/1ps
module tb_serial_seq_tx;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    serial_seq_if #(.WIDTH(8)) if_a ();
    serial_seq_if #(.WIDTH(8)) if_b ();
    serial_seq_if #(.WIDTH(8)) if_c ();
    serial_seq_if #(.WIDTH(8)) if_d ();

    serial_seq_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    serial_seq_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    serial_seq_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    serial_seq_tx #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  v1;
        logic [7:0]  v2;
        logic [15:0] seq;
        logic        e_out;
        logic        e_ov;

        n_total = 0;
        n_bad   = 0;
        if_a.data_in = '0; if_a.data_valid = 1'b0;
        if_b.data_in = '0; if_b.data_valid = 1'b0;
        if_c.data_in = '0; if_c.data_valid = 1'b0;
        if_d.data_in = '0; if_d.data_valid = 1'b0;
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_out",  if_a.out, 0);
        chk("rst_ov",   if_a.out_valid, 0);
        chk("rst_wd",   if_a.word_done, 0);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_rdy",  if_a.data_ready, 1);
        chk("rst_rdy_b", if_b.data_ready, 1);
        chk("rst_rdy_d", if_d.data_ready, 1);

        // single word B2, GAP=1, MSB first
        if_a.data_in = 8'hB2; if_a.data_valid = 1'b1;
        tick();
        if_a.data_valid = 1'b0;
        v1 = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_out%0d", i),  if_a.out, v1[7-i]);
            chk($sformatf("t1_ov%0d", i),   if_a.out_valid, 1);
            chk($sformatf("t1_wd%0d", i),   if_a.word_done, (i == 7));
            chk($sformatf("t1_rdy%0d", i),  if_a.data_ready, 0);
            chk($sformatf("t1_busy%0d", i), if_a.busy, 1);
            tick();
        end
        chk("t1_gap_out",  if_a.out, 0);
        chk("t1_gap_ov",   if_a.out_valid, 0);
        chk("t1_gap_wd",   if_a.word_done, 0);
        chk("t1_gap_busy", if_a.busy, 1);
        chk("t1_gap_rdy",  if_a.data_ready, 1);
        tick();
        chk("t1_idle_busy", if_a.busy, 0);
        chk("t1_idle_rdy",  if_a.data_ready, 1);
        chk("t1_idle_ov",   if_a.out_valid, 0);

        // back-to-back F0 then 0F, GAP=0
        if_b.data_in = 8'hF0; if_b.data_valid = 1'b1;
        tick();
        if_b.data_in = 8'h0F;
        seq = 16'b1111000000001111;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_out%0d", i), if_b.out, seq[15-i]);
            chk($sformatf("t2_ov%0d", i),  if_b.out_valid, 1);
            chk($sformatf("t2_wd%0d", i),  if_b.word_done, (i == 7 || i == 15));
            chk($sformatf("t2_rdy%0d", i), if_b.data_ready, (i == 7 || i == 15));
            if (i == 8) if_b.data_valid = 1'b0;
            tick();
        end
        chk("t2_end_ov",   if_b.out_valid, 0);
        chk("t2_end_busy", if_b.busy, 0);
        chk("t2_end_rdy",  if_b.data_ready, 1);

        // LSB first, 01
        if_c.data_in = 8'h01; if_c.data_valid = 1'b1;
        tick();
        if_c.data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_out%0d", i), if_c.out, (i == 0));
            chk($sformatf("t3_ov%0d", i),  if_c.out_valid, 1);
            chk($sformatf("t3_wd%0d", i),  if_c.word_done, (i == 7));
            tick();
        end
        chk("t3_gap_ov", if_c.out_valid, 0);

        // backpressure: AA offered mid-word, taken only on the gap cycle
        tick();
        if_a.data_in = 8'h3C; if_a.data_valid = 1'b1;
        tick();
        if_a.data_valid = 1'b0;
        v1 = 8'h3C;
        v2 = 8'hAA;
        for (int i = 0; i < 18; i++) begin
            e_out = 1'b0;
            e_ov  = 1'b0;
            if (i < 8) begin
                e_out = v1[7-i]; e_ov = 1'b1;
            end else if (i >= 9 && i <= 16) begin
                e_out = v2[16-i]; e_ov = 1'b1;
            end
            chk($sformatf("t4_out%0d", i), if_a.out, e_out);
            chk($sformatf("t4_ov%0d", i),  if_a.out_valid, e_ov);
            chk($sformatf("t4_rdy%0d", i), if_a.data_ready, (i == 8 || i == 17));
            chk($sformatf("t4_wd%0d", i),  if_a.word_done, (i == 7 || i == 16));
            if (i == 3) begin
                if_a.data_in = 8'hAA; if_a.data_valid = 1'b1;
            end
            if (i == 9) if_a.data_valid = 1'b0;
            tick();
        end
        chk("t4_idle_busy", if_a.busy, 0);

        // asynchronous reset on bit 3 of FF
        if_a.data_in = 8'hFF; if_a.data_valid = 1'b1;
        tick();
        if_a.data_valid = 1'b0;
        tick();
        tick();
        chk("t5_pre_ov", if_a.out_valid, 1);
        chk("t5_pre_out", if_a.out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out",  if_a.out, 0);
        chk("t5_rst_ov",   if_a.out_valid, 0);
        chk("t5_rst_busy", if_a.busy, 0);
        chk("t5_rst_rdy",  if_a.data_ready, 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_post_ov%0d", i),   if_a.out_valid, 0);
            chk($sformatf("t5_post_out%0d", i),  if_a.out, 0);
            chk($sformatf("t5_post_rdy%0d", i),  if_a.data_ready, 1);
            chk($sformatf("t5_post_busy%0d", i), if_a.busy, 0);
        end

        // GAP=3 back-to-back C3 then 81
        if_d.data_in = 8'hC3; if_d.data_valid = 1'b1;
        tick();
        if_d.data_in = 8'h81;
        v1 = 8'hC3;
        v2 = 8'h81;
        for (int i = 0; i < 20; i++) begin
            e_out = 1'b0;
            e_ov  = 1'b0;
            if (i < 8) begin
                e_out = v1[7-i]; e_ov = 1'b1;
            end else if (i >= 11 && i <= 18) begin
                e_out = v2[18-i]; e_ov = 1'b1;
            end
            chk($sformatf("t6_out%0d", i),  if_d.out, e_out);
            chk($sformatf("t6_ov%0d", i),   if_d.out_valid, e_ov);
            chk($sformatf("t6_busy%0d", i), if_d.busy, 1);
            chk($sformatf("t6_rdy%0d", i),  if_d.data_ready, (i == 10));
            chk($sformatf("t6_wd%0d", i),   if_d.word_done, (i == 7 || i == 18));
            if (i == 11) if_d.data_valid = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_seq_tx.md
Name: serial_seq_tx

Overview:
- Serial bit-stream transmitter; the driving end of the one-bit-per-clock `in` stream consumed by the team's sequence-detector FSMs.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `out`.
- Frames each word with `out_valid` and inserts a programmable idle gap between words.
- Replaces ad-hoc random bit stimulus with a synthesizable, deterministic pattern source for the detector under test.

Parameters:
- WIDTH, 8, bits per word (2..32).
- GAP, 1, idle cycles inserted after each word (0..15); `out` = 0 and `out_valid` = 0 during the gap.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  parallel word to transmit.
- data_valid  input  1  data_in valid; held until accepted.
- data_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit (registered).
- out_valid  output  1  `out` carries a payload bit (registered).
- busy  output  1  state != IDLE.
- word_done  output  1  one-cycle pulse, coincident with the last bit of a word.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. Assertion clears all state immediately; deassertion is sampled at clk.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, gap counter = 0, out = 0, out_valid = 0, word_done = 0, busy = 0, data_ready = 1.
- States:
  - IDLE: waiting for a word.
  - SHIFT: driving bits.
  - GAP: driving idle cycles.
- Accept: a handshake occurs at a clk edge when data_valid && data_ready. data_in is captured into the shift register, bit counter = WIDTH-1, and state moves to SHIFT.
- Latency: the first payload bit appears on out/out_valid in the cycle immediately after the accepting edge.
- SHIFT:
  - Each cycle drives the current head bit (MSB or LSB per MSB_FIRST) with out_valid = 1.
  - The register shifts and the bit counter decrements.
  - On the cycle with counter == 0, word_done = 1.
  - Next state: GAP if GAP > 0, with gap counter = GAP-1.
  - If GAP == 0: SHIFT again if a handshake occurs on that edge, otherwise IDLE.
- GAP: out = 0, out_valid = 0. The gap counter decrements; at 0 the next state is SHIFT on a handshake, otherwise IDLE.
- data_ready:
  - 1 in IDLE.
  - 1 on the last SHIFT cycle when GAP == 0.
  - 1 on the last GAP cycle when GAP > 0.
  - 0 otherwise.
  - data_ready is combinational from state and counters only, never from data_valid.
- Resulting throughput: exactly WIDTH + GAP cycles per word when data_valid is held continuously. No bubbles beyond GAP.
- data_valid while data_ready = 0: ignored. data_in is not sampled; the upstream holds the word.
- IDLE outputs: out = 0, out_valid = 0, word_done = 0.
- Reset mid-word: the word is discarded immediately and asynchronously, with no partial completion. After release the block starts in IDLE with data_ready = 1.
- Widths:
  - Bit counter: $clog2(WIDTH) bits.
  - Gap counter: 4 bits.
  - Counters never wrap below 0; the transition occurs at 0.
- out_valid and word_done are registered outputs (no combinational path from inputs to out, out_valid or word_done).

Decomposition:
- Package serial_seq_pkg: `typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;` plus constant GAP_CNT_W = 4.
- Sub-module serial_seq_shreg: WIDTH-bit load/shift register with MSB_FIRST direction and a head-bit output.
- serial_seq_tx contains the FSM, the counters and the handshake logic.

Test Plan:
- Reset then single word, WIDTH = 8, GAP = 1, data_in = 8'hB2 -> `out` = 1,0,1,1,0,0,1,0 on 8 consecutive cycles, with out_valid high for those 8 cycles. word_done pulses on bit 8. Then 1 cycle with out = 0, out_valid = 0, then IDLE with data_ready = 1.
- Back-to-back, GAP = 0, data_valid held high with 8'hF0 then 8'h0F -> 16 contiguous out_valid cycles carrying 1111000000001111. word_done pulses at cycles 8 and 16. data_ready is high on cycles 8 and 16 only.
- MSB_FIRST = 0, data_in = 8'h01 -> out = 1,0,0,0,0,0,0,0.
- Backpressure: data_valid asserted with 8'hAA mid-word -> not accepted until data_ready. The second word starts exactly WIDTH + GAP cycles after the first.
- rst_n pulled low on bit 3 of 8'hFF -> out, out_valid and busy go to 0 immediately, asynchronously. After release, data_ready = 1 and no residual bits are emitted.
- GAP = 3, two words back-to-back -> exactly 3 idle cycles between the words; busy stays high throughout the gap.
